// File: rtl/priority_encoder_8x3_seq.sv
// priority_encoder_8x3_seq: captures rising edges on eight request lines into
// a pending register and hands out one pending index per cycle over a
// valid/ready handshake.
// Build option: define PRIORITY_ENCODER_8X3_SEQ_RR_EN to replace the fixed
// lowest-index selection with round-robin selection starting after the last
// loaded index.

// Per-request cell: next pending bit and overflow contribution for one index.
module pe8_lane (
  input  logic rise,
  input  logic pend_q,
  input  logic load_hit,
  output logic pend_d,
  output logic ovf_hit
);
  // A new rise wins over the load-clear so an event is never dropped.
  assign pend_d  = rise | (pend_q & ~load_hit);
  // Merging into a bit that stays pending means an event was lost.
  assign ovf_hit = rise & pend_q & ~load_hit;
endmodule

module priority_encoder_8x3_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       clr,
  input  logic       ready,
  output logic [2:0] y,
  output logic       valid,
  output logic [7:0] pending,
  output logic       overflow
);

  logic [7:0] req_q, req_d;
  logic [7:0] pending_q, pending_d;
  logic [2:0] y_q, y_d;
  logic       valid_q, valid_d;
  logic       overflow_q, overflow_d;

  logic [7:0] rise;
  logic [7:0] load_mask;
  logic [7:0] lane_pend;
  logic [7:0] lane_ovf;
  logic [2:0] sel;
  logic       load;

`ifdef PRIORITY_ENCODER_8X3_SEQ_RR_EN
  logic [2:0] last_q, last_d;
  logic [2:0] idx;
  logic       found;

  // Round-robin pick: scan from last+1 upward, wrapping, first pending bit wins.
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = last_q + 3'(i);
      if (!found && pending_q[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end
`else
  // Fixed priority pick: lowest pending index wins.
  always_comb begin
    sel = '0;
    for (int i = 7; i >= 0; i--) begin
      if (pending_q[i]) sel = 3'(i);
    end
  end
`endif

  assign rise      = req & ~req_q;
  assign load      = (~valid_q | ready) & (|pending_q);
  assign load_mask = load ? (8'b1 << sel) : 8'b0;

  genvar b;
  generate
    for (b = 0; b < 8; b++) begin : g_lane
      pe8_lane u_lane (
        .rise     (rise[b]),
        .pend_q   (pending_q[b]),
        .load_hit (load_mask[b]),
        .pend_d   (lane_pend[b]),
        .ovf_hit  (lane_ovf[b])
      );
    end
  endgenerate

  // Next-state: clr flushes everything except the edge-detect history.
  always_comb begin
    req_d      = req;
    pending_d  = lane_pend;
    overflow_d = overflow_q | (|lane_ovf);
    valid_d    = load | (valid_q & ~ready);
    y_d        = load ? sel : y_q;
`ifdef PRIORITY_ENCODER_8X3_SEQ_RR_EN
    last_d     = load ? sel : last_q;
`endif
    if (clr) begin
      pending_d  = '0;
      overflow_d = 1'b0;
      valid_d    = 1'b0;
      y_d        = '0;
`ifdef PRIORITY_ENCODER_8X3_SEQ_RR_EN
      last_d     = 3'd7;
`endif
    end
  end

  // State registers; async reset clears all state, including edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= '0;
      pending_q  <= '0;
      y_q        <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
`ifdef PRIORITY_ENCODER_8X3_SEQ_RR_EN
      last_q     <= 3'd7;
`endif
    end else begin
      req_q      <= req_d;
      pending_q  <= pending_d;
      y_q        <= y_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
`ifdef PRIORITY_ENCODER_8X3_SEQ_RR_EN
      last_q     <= last_d;
`endif
    end
  end

  assign y        = y_q;
  assign valid    = valid_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_priority_encoder_8x3_seq.sv
// Bench for priority_encoder_8x3_seq: directed scenario tasks plus a random
// run, all checked against an event-level reference model.
module tb_priority_encoder_8x3_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       clr;
  logic       ready;
  logic [2:0] y;
  logic       valid;
  logic [7:0] pending;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  priority_encoder_8x3_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .clr      (clr),
    .ready    (ready),
    .y        (y),
    .valid    (valid),
    .pending  (pending),
    .overflow (overflow)
  );

  // Reference model: a set of outstanding events plus a one-slot output.
  bit [7:0] m_prev;
  bit       m_pend [8];
  int       m_y;
  bit       m_valid;
  bit       m_ovf;
  int       m_last;

  function automatic bit [7:0] m_pend_vec();
    bit [7:0] v = '0;
    for (int i = 0; i < 8; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  function automatic int m_pick();
`ifdef PRIORITY_ENCODER_8X3_SEQ_RR_EN
    for (int k = 1; k <= 8; k++) if (m_pend[(m_last + k) % 8]) return (m_last + k) % 8;
`else
    for (int k = 0; k < 8; k++) if (m_pend[k]) return k;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_prev = '0;
    for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
    m_y = 0; m_valid = 1'b0; m_ovf = 1'b0; m_last = 7;
  endtask

  task automatic model_edge();
    bit [7:0] newev;
    int s;
    if (!rst_n) begin model_reset(); return; end
    newev  = req & ~m_prev;
    m_prev = req;
    if (clr) begin
      for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
      m_valid = 1'b0; m_ovf = 1'b0; m_y = 0; m_last = 7;
      return;
    end
    s = -1;
    if ((!m_valid || ready) && m_count() > 0) s = m_pick();
    for (int i = 0; i < 8; i++)
      if (newev[i] && m_pend[i] && i != s) m_ovf = 1'b1;
    if (s >= 0) begin
      m_pend[s] = 1'b0; m_y = s; m_valid = 1'b1; m_last = s;
    end else if (m_valid && ready) begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < 8; i++) if (newev[i]) m_pend[i] = 1'b1;
  endtask

  function automatic logic [12:0] obs();
    return {y, valid, pending, overflow};
  endfunction

  function automatic logic [12:0] expv();
    return {3'(m_y), m_valid, m_pend_vec(), m_ovf};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 8'hFF; clr = 1'b0; ready = 1'b0;
    model_reset();
    repeat (2) step();
    n_tests++;
    if (obs() !== 13'h0) begin
      n_fail++; $display("FAIL reset_idle: got %h required %h", obs(), 13'h0);
    end
    rst_n = 1'b1;
    step();
    n_tests++;
    if (pending !== 8'hFF || valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_edge1: got pending=%h valid=%b required pending=ff valid=0", pending, valid);
    end
    step();
    n_tests++;
    if (valid !== 1'b1 || y !== 3'd0) begin
      n_fail++; $display("FAIL reset_edge2: got valid=%b y=%0d required valid=1 y=0", valid, y);
    end
    ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL reset_drain: got %h required %h", obs(), expv());
      end
    end
    req = 8'h00;
    step();
  endtask

  task automatic test_single();
    int hits = 0;
    ready = 1'b1; req = 8'h20;
    step();
    req = 8'h00;
    for (int i = 0; i < 5; i++) begin
      if (valid && y == 3'd5) hits++;
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL single: got %h required %h", obs(), expv());
      end
      step();
    end
    n_tests++;
    if (hits != 1 || pending !== 8'h00) begin
      n_fail++; $display("FAIL single_once: got hits=%0d pending=%h required hits=1 pending=00", hits, pending);
    end
  endtask

  task automatic test_priority_backpressure();
    int got[$];
    ready = 1'b0; req = 8'h54;
    step();
    req = 8'h00;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (y !== 3'd2 || valid !== 1'b1 || obs() !== expv()) begin
        n_fail++; $display("FAIL prio_hold: got %h required %h (y=2 valid=1)", obs(), expv());
      end
    end
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (valid) got.push_back(int'(y));
      step();
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL prio_drain: got %h required %h", obs(), expv());
      end
    end
    n_tests++;
    if (got.size() != 3 || got[0] != 2 || got[1] != 4 || got[2] != 6) begin
      n_fail++; $display("FAIL prio_order: got %p required '{2,4,6}", got);
    end
  endtask

  task automatic test_round_robin();
    int got[$];
    bit alt_ok = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req = (i % 2 == 0) ? 8'h09 : 8'h00;
      if (valid) got.push_back(int'(y));
      step();
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL rr_cycle: got %h required %h", obs(), expv());
      end
    end
    req = 8'h00;
    repeat (3) step();
`ifdef PRIORITY_ENCODER_8X3_SEQ_RR_EN
    for (int i = 1; i < got.size(); i++) if (got[i] == got[i-1]) alt_ok = 1'b0;
    n_tests++;
    if (!alt_ok || got.size() < 8) begin
      n_fail++; $display("FAIL rr_alternate: got %p required alternating 0/3", got);
    end
`else
    alt_ok = (got.size() >= 8);
    n_tests++;
    if (!alt_ok || got[0] != 0) begin
      n_fail++; $display("FAIL fixed_first: got %p required first=0, >=8 transfers", got);
    end
`endif
  endtask

  task automatic test_overflow();
    int ones = 0;
    clr = 1'b1; step(); clr = 1'b0;
    ready = 1'b0;
    req = 8'h01; step(); req = 8'h00; step();
    req = 8'h02; step(); req = 8'h00; step();
    req = 8'h02; step(); req = 8'h00; step();
    n_tests++;
    if (overflow !== 1'b1 || obs() !== expv()) begin
      n_fail++; $display("FAIL ovf_set: got %h required %h (overflow=1)", obs(), expv());
    end
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (valid && y == 3'd1) ones++;
      step();
    end
    n_tests++;
    if (ones != 1) begin
      n_fail++; $display("FAIL ovf_merge: got %0d y=1 transfers required 1", ones);
    end
    clr = 1'b1; step(); clr = 1'b0;
    ready = 1'b0;
    req = 8'h01; step(); req = 8'h00; step();
    req = 8'h02; step(); req = 8'h00; step();
    ready = 1'b1; req = 8'h02;
    step();
    req = 8'h00; ones = 0;
    for (int i = 0; i < 6; i++) begin
      if (valid && y == 3'd1) ones++;
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL reload_cycle: got %h required %h", obs(), expv());
      end
      step();
    end
    n_tests++;
    if (ones != 2 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL reload_same_cycle: got transfers=%0d overflow=%b required 2 and 0", ones, overflow);
    end
  endtask

  task automatic test_flush();
    int seen = 0;
    clr = 1'b1; step(); clr = 1'b0;
    ready = 1'b0;
    req = 8'h10; step(); req = 8'h00; step();
    req = 8'h0F; step(); req = 8'h00; step();
    n_tests++;
    if (pending !== 8'h0F || valid !== 1'b1) begin
      n_fail++; $display("FAIL flush_setup: got pending=%h valid=%b required 0f and 1", pending, valid);
    end
    clr = 1'b1; req = 8'h80;
    step();
    clr = 1'b0;
    n_tests++;
    if ({valid, pending, overflow} !== 10'h0) begin
      n_fail++; $display("FAIL flush: got valid=%b pending=%h overflow=%b required all 0", valid, pending, overflow);
    end
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) req = 8'h00;
      step();
      if (valid) seen++;
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL flush_after: got %h required %h", obs(), expv());
      end
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++; $display("FAIL flush_no_event: got %0d valid cycles required 0", seen);
    end
  endtask

  task automatic test_reset_midstream();
    ready = 1'b0; req = 8'hA5; step(); req = 8'h5A; step();
    rst_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (obs() !== 13'h0) begin
      n_fail++; $display("FAIL async_reset: got %h required %h", obs(), 13'h0);
    end
    req = 8'h00;
    step();
    rst_n = 1'b1;
    step();
    n_tests++;
    if (obs() !== expv()) begin
      n_fail++; $display("FAIL after_reset: got %h required %h", obs(), expv());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      req   = 8'($urandom);
      ready = ($urandom_range(3) != 0);
      clr   = ($urandom_range(49) == 0);
      step();
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL random[%0d]: got %h required %h", i, obs(), expv());
      end
    end
    clr = 1'b0; req = 8'h00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority_backpressure();
    test_round_robin();
    test_overflow();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
